// File: rtl/ctrl_seq16_if.sv
// Instruction-memory port plus the control bundle the sequencer drives into the
// register group and ALU.
interface ctrl_seq16_if #(
    parameter int PC_W = 12
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic            alu_zero;
    logic [3:0]      alu_op;
    logic [3:0]      r_addrA;
    logic [3:0]      r_addrB;
    logic [3:0]      w_addr;
    logic [3:0]      i_d1;
    logic [3:0]      i_d2;
    logic            regwr;
    logic [PC_W-1:0] pc;
    logic            halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, alu_zero,
        output alu_op, r_addrA, r_addrB, w_addr, i_d1, i_d2,
        output regwr, pc, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, alu_zero,
        input  alu_op, r_addrA, r_addrB, w_addr, i_d1, i_d2,
        input  regwr, pc, halted
    );
endinterface

// File: rtl/ctrl_seq16.sv
// Fetch/decode/exec/writeback sequencer for the 16-bit CPU: owns the PC, decodes
// each instruction word into register-group controls and pulses regwr in WB.
module ctrl_seq16 #(
    parameter int PC_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_seq16_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_SUBI = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    logic [2:0]      stateReg, stateNext;
    logic [PC_W-1:0] pcReg, pcNext;
    logic [15:0]     irReg, irNext;

    logic [3:0] aluOpReg, rAddrAReg, rAddrBReg, wAddrReg, iD1Reg, iD2Reg;
    logic [3:0] aluOpNext, rAddrANext, rAddrBNext, wAddrNext, iD1Next, iD2Next;

    logic [3:0]      opc, fldRd, fldRs, fldRt;
    logic            isWriteOp;
    logic [PC_W-1:0] pcInc, brTarget, jmpTarget;

    assign opc   = irReg[15:12];
    assign fldRd = irReg[11:8];
    assign fldRs = irReg[7:4];
    assign fldRt = irReg[3:0];

    // Opcodes 1..9 are exactly the ones that end in a writeback cycle.
    assign isWriteOp = (opc >= OP_ADD) && (opc <= OP_SUBI);

    assign pcInc    = pcReg + {{(PC_W-1){1'b0}}, 1'b1};
    assign brTarget = pcReg + {{(PC_W-8){irReg[7]}}, irReg[7:0]};

    // Jump target is the low 12 instruction bits, zero-extended for wider PCs.
    genvar gi;
    generate
        for (gi = 0; gi < PC_W; gi++) begin : g_jmp
            if (gi < 12) begin : g_bit
                assign jmpTarget[gi] = irReg[gi];
            end else begin : g_zero
                assign jmpTarget[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        aluOpNext  = 4'h0;
        rAddrANext = 4'h0;
        rAddrBNext = 4'h0;
        wAddrNext  = 4'h0;
        iD1Next    = 4'h0;
        iD2Next    = 4'h0;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                aluOpNext  = opc;
                rAddrANext = fldRs;
                rAddrBNext = fldRt;
                wAddrNext  = fldRd;
            end
            OP_ADDI, OP_SUBI: begin
                // imm4 also drives r_addrB so that imm4=0 reads R0 in register mode.
                aluOpNext  = (opc == OP_ADDI) ? OP_ADD : OP_SUB;
                rAddrANext = fldRs;
                rAddrBNext = fldRt;
                iD2Next    = fldRt;
                wAddrNext  = fldRd;
            end
            OP_BZ: begin
                rAddrANext = fldRd;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        irNext    = irReg;
        case (stateReg)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    irNext    = bus.imem_rdata;
                    stateNext = S_DECODE;
                end
            end
            S_DECODE: stateNext = S_EXEC;
            S_EXEC: begin
                if (isWriteOp) begin
                    stateNext = S_WB;
                end else if (opc == OP_JMP) begin
                    pcNext    = jmpTarget;
                    stateNext = S_FETCH;
                end else if (opc == OP_BZ) begin
                    pcNext    = bus.alu_zero ? brTarget : pcInc;
                    stateNext = S_FETCH;
                end else if (opc == OP_HALT) begin
                    stateNext = S_HALT;
                end else begin
                    pcNext    = pcInc;
                    stateNext = S_FETCH;
                end
            end
            S_WB: begin
                pcNext    = pcInc;
                stateNext = S_FETCH;
            end
            S_HALT: stateNext = S_HALT;
            default: stateNext = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= S_FETCH;
            pcReg    <= '0;
            irReg    <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            irReg    <= irNext;
        end
    end

    // Decoded controls load once in DECODE and stay put through EXEC, WB and HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluOpReg  <= '0;
            rAddrAReg <= '0;
            rAddrBReg <= '0;
            wAddrReg  <= '0;
            iD1Reg    <= '0;
            iD2Reg    <= '0;
        end else if (stateReg == S_DECODE) begin
            aluOpReg  <= aluOpNext;
            rAddrAReg <= rAddrANext;
            rAddrBReg <= rAddrBNext;
            wAddrReg  <= wAddrNext;
            iD1Reg    <= iD1Next;
            iD2Reg    <= iD2Next;
        end
    end

    // rst gates the request directly so a fetch is withdrawn without waiting for a clock.
    assign bus.imem_req  = (stateReg == S_FETCH) && !rst;
    assign bus.imem_addr = pcReg;
    assign bus.regwr     = (stateReg == S_WB);
    assign bus.halted    = (stateReg == S_HALT);
    assign bus.pc        = pcReg;
    assign bus.alu_op    = aluOpReg;
    assign bus.r_addrA   = rAddrAReg;
    assign bus.r_addrB   = rAddrBReg;
    assign bus.w_addr    = wAddrReg;
    assign bus.i_d1      = iD1Reg;
    assign bus.i_d2      = iD2Reg;
endmodule

// File: tb/tb_ctrl_seq16.sv
// Bench for ctrl_seq16: a table of instructions with expected decode and PC,
// checked through a scoreboard queue, plus hand-written halt and reset sequences.
module tb_ctrl_seq16;
    logic clk;
    logic rst;

    ctrl_seq16_if #(.PC_W(12)) ifc ();

    ctrl_seq16 #(.PC_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    typedef struct {
        logic [15:0] word;
        int          ackDelay;
        logic        aluZero;
        logic [3:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  w;
        logic [3:0]  i2;
        logic        expWr;
        logic [11:0] expPc;
    } vec_t;

    vec_t vecs[$];
    vec_t sbQ[$];
    int   tests = 0;
    int   fails = 0;
    int   regwrCount = 0;
    logic [11:0] modelPc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ifc.regwr) regwrCount <= regwrCount + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] word, input int dly, input logic z,
                                input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] w, input logic [3:0] i2, input logic wr,
                                input logic [11:0] pcAfter);
        vec_t v;
        v.word = word; v.ackDelay = dly; v.aluZero = z;
        v.op = op; v.a = a; v.b = b; v.w = w; v.i2 = i2;
        v.expWr = wr; v.expPc = pcAfter;
        return v;
    endfunction

    // Entered at a negedge with the DUT in FETCH; leaves at a negedge back in FETCH.
    task automatic runVec(input vec_t v);
        vec_t e;
        int   wr0;
        wr0 = regwrCount;
        check("fetch_req", int'(ifc.imem_req), 1);
        check("fetch_addr", int'(ifc.imem_addr), int'(modelPc));
        for (int d = 0; d < v.ackDelay; d++) begin
            @(negedge clk);
            check("wait_req", int'(ifc.imem_req), 1);
            check("wait_addr", int'(ifc.imem_addr), int'(modelPc));
        end
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = v.word;
        sbQ.push_back(v);
        @(negedge clk);
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 16'($urandom);
        check("decode_req", int'(ifc.imem_req), 0);
        @(negedge clk);
        ifc.alu_zero = v.aluZero;
        if (sbQ.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sbQ.pop_front();
            check("alu_op", int'(ifc.alu_op), int'(e.op));
            check("r_addrA", int'(ifc.r_addrA), int'(e.a));
            check("r_addrB", int'(ifc.r_addrB), int'(e.b));
            check("w_addr", int'(ifc.w_addr), int'(e.w));
            check("i_d1", int'(ifc.i_d1), 0);
            check("i_d2", int'(ifc.i_d2), int'(e.i2));
            check("exec_regwr", int'(ifc.regwr), 0);
        end
        @(negedge clk);
        if (v.expWr) begin
            check("wb_regwr", int'(ifc.regwr), 1);
            check("wb_req", int'(ifc.imem_req), 0);
            check("wb_alu_op", int'(ifc.alu_op), int'(v.op));
            @(negedge clk);
        end
        check("after_regwr", int'(ifc.regwr), 0);
        check("regwr_pulses", regwrCount - wr0, v.expWr ? 1 : 0);
        check("pc_after", int'(ifc.pc), int'(v.expPc));
        modelPc = v.expPc;
        $display("[TB] instr %04h ack_delay %0d zero %0b -> pc %03h regwr_pulses %0d",
                 v.word, v.ackDelay, v.aluZero, ifc.pc, regwrCount - wr0);
    endtask

    initial begin
        vec_t v;
        int   wr0;
        //          word      dly z     op    A     B     W     i2    wr    pc
        vecs.push_back(mk(16'h1123, 0, 1'b0, 4'h1, 4'h2, 4'h3, 4'h1, 4'h0, 1'b1, 12'h001));
        vecs.push_back(mk(16'h8455, 3, 1'b0, 4'h1, 4'h5, 4'h5, 4'h4, 4'h5, 1'b1, 12'h002));
        vecs.push_back(mk(16'hF010, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h010));
        vecs.push_back(mk(16'hD2FE, 0, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 12'h00E));
        vecs.push_back(mk(16'hF010, 1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h010));
        vecs.push_back(mk(16'hD2FE, 0, 1'b0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 12'h011));
        vecs.push_back(mk(16'h2ABC, 1, 1'b1, 4'h2, 4'hB, 4'hC, 4'hA, 4'h0, 1'b1, 12'h012));
        vecs.push_back(mk(16'h9730, 0, 1'b0, 4'h2, 4'h3, 4'h0, 4'h7, 4'h0, 1'b1, 12'h013));
        vecs.push_back(mk(16'h3111, 2, 1'b0, 4'h3, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 12'h014));
        vecs.push_back(mk(16'h6F0E, 0, 1'b1, 4'h6, 4'h0, 4'hE, 4'hF, 4'h0, 1'b1, 12'h015));
        vecs.push_back(mk(16'hB123, 0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h016));
        vecs.push_back(mk(16'hFFFF, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'hFFF));
        vecs.push_back(mk(16'h0000, 0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000));
        vecs.push_back(mk(16'hD07F, 0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h07F));
        vecs.push_back(mk(16'hD380, 0, 1'b1, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 12'hFFF));
        vecs.push_back(mk(16'hD301, 0, 1'b1, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 12'h000));
        vecs.push_back(mk(16'hF123, 0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 12'h123));
        vecs.push_back(mk(16'h7456, 0, 1'b0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h0, 1'b1, 12'h124));
        vecs.push_back(mk(16'h5DEF, 0, 1'b0, 4'h5, 4'hE, 4'hF, 4'hD, 4'h0, 1'b1, 12'h125));
        vecs.push_back(mk(16'h4010, 0, 1'b0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 12'h126));

        rst = 1'b1;
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 16'h0;
        ifc.alu_zero   = 1'b0;
        modelPc = 12'h000;
        repeat (2) @(negedge clk);
        check("rst_req", int'(ifc.imem_req), 0);
        check("rst_pc", int'(ifc.pc), 0);
        check("rst_regwr", int'(ifc.regwr), 0);
        check("rst_halted", int'(ifc.halted), 0);
        check("rst_alu_op", int'(ifc.alu_op), 0);
        check("rst_w_addr", int'(ifc.w_addr), 0);
        rst = 1'b0;
        #1;

        foreach (vecs[k]) runVec(vecs[k]);

        // HALT: stop fetching, freeze outputs, ignore stray acks.
        wr0 = regwrCount;
        check("halt_fetch_addr", int'(ifc.imem_addr), 12'h126);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 16'hE000;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("halted", int'(ifc.halted), 1);
        for (int c = 0; c < 20; c++) begin
            ifc.imem_ack   = 1'($urandom);
            ifc.imem_rdata = 16'h1123;
            @(negedge clk);
            check("halt_hold", int'(ifc.halted), 1);
            check("halt_req", int'(ifc.imem_req), 0);
            check("halt_pc", int'(ifc.pc), 12'h126);
            check("halt_alu_op", int'(ifc.alu_op), 0);
            check("halt_r_addrA", int'(ifc.r_addrA), 0);
        end
        ifc.imem_ack = 1'b0;
        check("halt_no_regwr", regwrCount - wr0, 0);
        $display("[TB] halt held 20 cycles at pc %03h", ifc.pc);

        rst = 1'b1;
        #1;
        check("halt_rst_pc", int'(ifc.pc), 0);
        check("halt_rst_halted", int'(ifc.halted), 0);
        check("halt_rst_req", int'(ifc.imem_req), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("resume_req", int'(ifc.imem_req), 1);
        check("resume_addr", int'(ifc.imem_addr), 0);
        $display("[TB] reset out of halt -> fetch at %03h", ifc.imem_addr);

        // Reset during EXEC of an ADD aborts it with no write.
        wr0 = regwrCount;
        @(negedge clk);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 16'h1123;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        @(negedge clk);
        check("abort_decoded", int'(ifc.alu_op), 1);
        rst = 1'b1;
        #1;
        check("abort_alu_op", int'(ifc.alu_op), 0);
        check("abort_r_addrA", int'(ifc.r_addrA), 0);
        check("abort_r_addrB", int'(ifc.r_addrB), 0);
        check("abort_w_addr", int'(ifc.w_addr), 0);
        check("abort_i_d2", int'(ifc.i_d2), 0);
        check("abort_req", int'(ifc.imem_req), 0);
        check("abort_regwr", int'(ifc.regwr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_no_regwr", regwrCount - wr0, 0);
        check("abort_addr", int'(ifc.imem_addr), 0);
        check("abort_req_back", int'(ifc.imem_req), 1);
        $display("[TB] reset in EXEC aborted write, fetch at %03h", ifc.imem_addr);

        modelPc = 12'h000;
        v = vecs[0];
        runVec(v);
        check("sb_drained", sbQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ctrl_seq16.md
Name: ctrl_seq16

Overview:
- Multi-cycle fetch/decode/control sequencer for the 16-bit CPU. It sits directly upstream of the register group.
- Fetches 16-bit instructions over a req/ack instruction-memory port.
- Decodes each instruction into the register group's read addresses, write address, immediate nibbles and ALU op.
- Pulses regwr in a dedicated writeback cycle.
- Owns the PC and handles jumps, branch-on-zero and halt.

Parameters:
PC_W, 12, width of program counter and instruction address (word addressed)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (= pc)
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  16  instruction word
alu_zero  input  1  ALU result==0 flag, sampled in EXEC
alu_op  output  4  ALU operation code
r_addrA  output  4  register read address A
r_addrB  output  4  register read address B
w_addr  output  4  register write address
i_d1  output  4  immediate nibble 1 (0 = use register A)
i_d2  output  4  immediate nibble 2 (0 = use register B)
regwr  output  1  register write strobe, one cycle
pc  output  PC_W  current program counter
halted  output  1  sequencer stopped

Behaviour:
- Reset (async, immediate):
  - state=FETCH, pc=0.
  - imem_req, regwr and halted are 0.
  - alu_op, r_addrA, r_addrB, w_addr, i_d1 and i_d2 are 0.
  - Reset in any state, including mid-fetch, drops imem_req combinationally from rst and aborts the instruction without regwr.
- Instruction format: [15:12] opc, [11:8] rd, [7:4] rs, [3:0] rt/imm4; [7:0] off8 for BZ.
- States and transitions:
  - FETCH: imem_req=1, imem_addr=pc. Stays until imem_ack is sampled high; then the IR is latched and the next state is DECODE. imem_ack outside FETCH is ignored.
  - DECODE: decode fields are registered onto the outputs, which stay stable through EXEC and WB. Next state is EXEC.
  - EXEC: the register group and ALU settle combinationally.
    - ALU ops go to WB.
    - JMP: pc=instr[PC_W-1:0] (zero-extended if PC_W>12), next state FETCH.
    - BZ: if alu_zero then pc=pc+sext(off8) else pc=pc+1, next state FETCH.
    - HALT: next state HALT.
    - NOP/undefined: pc=pc+1, next state FETCH.
  - WB: regwr=1 for exactly this cycle, pc=pc+1, next state FETCH.
  - HALT: halted=1, imem_req=0, all other outputs held. Only rst exits this state.
- Decode per opcode (all fields not listed are 0):
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR: alu_op=opc, r_addrA=rs, r_addrB=rt, w_addr=rd.
  - 8 ADDI: alu_op=1, r_addrA=rs, r_addrB=imm4, i_d2=imm4, w_addr=rd. imm4=0 is therefore a register-mode read of R0.
  - 9 SUBI: as ADDI with alu_op=2.
  - 0 NOP and A-C undefined: no regwr.
  - D BZ: r_addrA=rd, alu_op=0 (pass A).
  - E HALT.
  - F JMP.
- Latency:
  - ALU instruction: 4 cycles with ack on the first FETCH cycle, plus one cycle per wait cycle.
  - JMP, BZ and NOP: 3 cycles.
- Arithmetic:
  - pc arithmetic is modulo 2^PC_W. Increment past max wraps to 0.
  - Branch target wraps in both directions.
  - off8 is sign-extended to PC_W.
- Write address and read addresses may coincide. The write lands on the WB clock edge, and the outputs are already stable, so the read-before-write value is what the ALU consumes.

Test Plan:
- Reset then ack at the first FETCH with rdata=0x1123 (ADD R1=R2+R3) -> DECODE drives r_addrA=2, r_addrB=3, w_addr=1, alu_op=1, i_d1=i_d2=0. regwr=1 only in cycle 4, pc=1 after WB.
- Word 0x8455 (ADDI R4=R5+5) with ack delayed 3 cycles -> imem_req held for 4 cycles, addr stable. i_d2=5, alu_op=1, regwr pulses once 6 cycles after fetch start.
- At pc=0x010, BZ 0xD2FE with alu_zero=1 -> pc=0x00E, no regwr. Repeat with alu_zero=0 -> pc=0x011.
- At pc=0xFFF, NOP 0x0000 -> pc wraps to 0x000. JMP 0xF123 -> pc=0x123, next imem_addr=0x123.
- HALT 0xE000 -> halted=1, imem_req=0, outputs frozen for 20 cycles. rst pulse -> pc=0, FETCH resumes.
- Assert rst in the EXEC cycle of an ADD -> regwr never asserts, all outputs 0 immediately. After release the first imem_addr is 0.
